// File: rtl/servo_array_controller.sv
// rtl/servo_array_controller.sv - SPI-programmed servo PWM array with shadowed per-period updates
// Three-byte SPI frames write shadow pulse widths / period; shadows go live at each period boundary.
module servo_array_controller #(
  parameter int NUM_CHANNELS   = 8,
  parameter int CLKS_PER_TICK  = 16,
  parameter int PULSE_MIN      = 500,
  parameter int PULSE_MAX      = 2500,
  parameter int DEFAULT_PULSE  = 1500,
  parameter int DEFAULT_PERIOD = 20000
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_spi_clock,
  input  logic                    i_mosi,
  input  logic                    i_select,
  output logic [NUM_CHANNELS-1:0] o_pwm,
  output logic                    o_frame_error
);

  localparam int          PW      = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int          AW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [8:0]  NCH9    = 9'(NUM_CHANNELS);
  localparam logic [15:0] MIN16   = 16'(PULSE_MIN);
  localparam logic [15:0] MAX16   = 16'(PULSE_MAX);
  localparam logic [15:0] DPULSE  = 16'(DEFAULT_PULSE);
  localparam logic [15:0] DPERIOD = 16'(DEFAULT_PERIOD);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_TICK - 1);

  typedef enum logic [1:0] {IDLE, GOT_ADDR, GOT_HI} byte_state_t;

  logic [2:0]  sclk_sync;
  logic [1:0]  mosi_sync;
  logic [1:0]  sel_sync;
  logic        sclk_fall;
  byte_state_t state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic [7:0]  byte_in;
  logic [7:0]  addr;
  logic [7:0]  data_hi;
  logic [15:0] value;
  logic        commit;

  logic [15:0] shadow_pulse [NUM_CHANNELS];
  logic [15:0] active_pulse [NUM_CHANNELS];
  logic [15:0] shadow_period;
  logic [15:0] active_period;
  logic [PW-1:0] prescale;
  logic [15:0] tick;
  logic        tick_wrap;
  logic        boundary;

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < MIN16)      return MIN16;
    else if (v > MAX16) return MAX16;
    else                return v;
  endfunction

  // sclk_sync[2] is the previous synchronized level, used only for edge detection
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign byte_in   = {shift, mosi_sync[1]};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sel_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_spi_clock};
      mosi_sync <= {mosi_sync[0], i_mosi};
      sel_sync  <= {sel_sync[0], i_select};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      addr          <= '0;
      data_hi       <= '0;
      value         <= '0;
      commit        <= 1'b0;
      o_frame_error <= 1'b0;
      shadow_period <= DPERIOD;
      for (int i = 0; i < NUM_CHANNELS; i++) shadow_pulse[i] <= DPULSE;
    end else begin
      o_frame_error <= 1'b0;
      commit        <= 1'b0;
      if (sel_sync[1]) begin
        if (bit_cnt != 3'd0 || state != IDLE) o_frame_error <= 1'b1;
        bit_cnt <= '0;
        state   <= IDLE;
      end else if (sclk_fall) begin
        shift   <= byte_in[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            IDLE:     begin addr <= byte_in;    state <= GOT_ADDR; end
            GOT_ADDR: begin data_hi <= byte_in; state <= GOT_HI;   end
            default:  begin
              value  <= {data_hi, byte_in};
              commit <= 1'b1;
              state  <= IDLE;
            end
          endcase
        end
      end
      // Commit only touches shadows; the active copies are reloaded at the boundary
      if (commit) begin
        if ({1'b0, addr} < NCH9)
          shadow_pulse[addr[AW-1:0]] <= clamp(value);
        else if (addr == 8'hFF && value > MAX16)
          shadow_period <= value;
        else
          o_frame_error <= 1'b1;
      end
    end
  end

  assign tick_wrap = (prescale == PRE_LAST);
  assign boundary  = tick_wrap && (tick == active_period - 16'd1);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prescale      <= '0;
      tick          <= '0;
      active_period <= DPERIOD;
      o_pwm         <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) active_pulse[i] <= DPULSE;
    end else begin
      prescale <= tick_wrap ? '0 : prescale + PW'(1);
      if (tick_wrap) tick <= boundary ? 16'd0 : tick + 16'd1;
      if (boundary) begin
        active_period <= shadow_period;
        for (int i = 0; i < NUM_CHANNELS; i++) active_pulse[i] <= shadow_pulse[i];
      end
      for (int i = 0; i < NUM_CHANNELS; i++) o_pwm[i] <= (tick < active_pulse[i]);
    end
  end

endmodule

// File: doc/servo_array_controller.md
SERVO_ARRAY_CONTROLLER -- requirements
Module: servo_array_controller

Interface
REQ-001 Parameter NUM_CHANNELS, default 8, number of PWM outputs (1..255) SHALL be supported.
REQ-002 Parameter CLKS_PER_TICK, default 16, SHALL set i_clock cycles per 1 us tick.
REQ-003 Parameters PULSE_MIN, default 500, and PULSE_MAX, default 2500, SHALL set the pulse clamp limits in ticks.
REQ-004 Parameter DEFAULT_PULSE, default 1500, SHALL set the pulse width after reset in ticks.
REQ-005 Parameter DEFAULT_PERIOD, default 20000, SHALL set the frame period after reset in ticks.
REQ-006 i_clock  input  1  SHALL be the single system clock; all logic SHALL run on its rising edge.
REQ-007 i_reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 i_spi_clock  input  1  SHALL be the SPI SCLK, asynchronous, CPOL=1.
REQ-009 i_mosi  input  1  SHALL be the SPI data input, asynchronous.
REQ-010 i_select  input  1  SHALL be the SPI chip select, active-low, asynchronous.
REQ-011 o_pwm  output  NUM_CHANNELS  SHALL be the registered servo PWM outputs.
REQ-012 o_frame_error  output  1  SHALL be a one-cycle pulse flagging a rejected or aborted frame.

Function
REQ-013 i_spi_clock, i_mosi and i_select SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected in the i_clock domain. Operation requires i_clock >= 8x SCLK.
REQ-014 SPI mode 0b10 (CPOL=1, CPHA=0): MOSI SHALL be sampled on each synchronized SCLK falling edge while select is low, MSB first, 8 bits per byte.
REQ-015 Frame = 3 bytes: ADDR, DATA_HI, DATA_LO. A byte counter SHALL cycle through the states IDLE -> GOT_ADDR -> GOT_HI -> commit -> IDLE.
REQ-016 Select high SHALL clear the bit and byte counters. If either counter was nonzero, the partial frame SHALL be discarded and o_frame_error SHALL pulse once.
REQ-017 Commit SHALL occur on the cycle after the 24th bit is sampled. value = {DATA_HI, DATA_LO}, unsigned 16 bit.
REQ-018 Commit with ADDR < NUM_CHANNELS: shadow_pulse[ADDR] SHALL receive value clamped to [PULSE_MIN, PULSE_MAX].
REQ-019 Commit with ADDR == 0xFF: if value > PULSE_MAX, shadow_period SHALL receive value. Otherwise the write SHALL be dropped and o_frame_error SHALL pulse.
REQ-020 Commit with any other ADDR SHALL be dropped, and o_frame_error SHALL pulse.
REQ-021 Consecutive frames without a select toggle SHALL be accepted; the byte counter SHALL wrap to IDLE after each commit.
REQ-022 Tick prescaler SHALL count 0..CLKS_PER_TICK-1. Tick counter SHALL count 0..active_period-1, advancing once per prescaler wrap.
REQ-023 Period boundary is the tick counter wrap to 0. At the boundary, active_pulse[] and active_period SHALL load from the shadows.
REQ-024 A commit in the same cycle as a boundary SHALL reach the shadow only. It SHALL take effect at the following boundary, not the current one.
REQ-025 o_pwm[i] SHALL be registered as (tick counter < active_pulse[i]), giving one cycle of latency from the counter.
REQ-026 All channels SHALL share one counter, so rising edges are aligned across channels.
REQ-027 Shadow and active registers SHALL persist across SPI aborts and errors.

Reset
REQ-028 Asserting i_reset_n low SHALL immediately force o_pwm=0 and o_frame_error=0, and clear all counters and synchronizers.
REQ-029 Reset SHALL load all shadow and active pulses with DEFAULT_PULSE, and both periods with DEFAULT_PERIOD.
REQ-030 Reset SHALL be released synchronously to i_clock. On the first cycle after release, o_pwm SHALL go all-ones.
REQ-031 Reset asserted mid-frame SHALL discard the frame, and no error pulse SHALL follow release.

Verification
REQ-032 Reset release with no SPI traffic -> every o_pwm high for 1500 ticks (24000 clocks) and low for 18500 ticks; repeats every 20000 ticks.
REQ-033 Frame 0x02,0x03,0xE8 sent mid-period -> ch2 keeps 1500 for the current period, then 1000 from the next boundary; other channels unchanged.
REQ-034 Frames to ch0 with 0x0064 and with 0xFFFF -> ch0 pulse clamped to 500 and to 2500 respectively; no error pulse.
REQ-035 Frame 0xFF,0x27,0x10 -> period becomes 10000 ticks at the next boundary. Frame 0xFF,0x01,0xF4 -> dropped, one o_frame_error pulse.
REQ-036 Select raised after 12 bits, then a valid frame to ch1 -> one error pulse, then ch1 updated correctly; ADDR 0x20 -> error pulse, no change.
REQ-037 Commit forced on the boundary cycle, and reset asserted mid-frame -> new value appears one period late; after reset, defaults are restored with no error pulse.
